// File: rtl/video_timing_gen.sv
`default_nettype none
// video_timing_gen: parametrised raster timing generator with sync/blank decodes,
// delayed hblank taps, line/frame pulses, frame counter and CPU interrupt sources.
//------------------------------------------------------------------------------
// Module  : video_timing_gen
// Brief   : Pixel/line counters, syncs, blanks, hblank taps and line IRQs
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module video_timing_gen #(
    parameter int HW        = 9,
    parameter int VW        = 8,
    parameter int HTOTAL    = 320,
    parameter int HBL_START = 256,
    parameter int HS_START  = 272,
    parameter int HS_END    = 304,
    parameter int HB_DLY1   = 4,
    parameter int HB_DLY2   = 8,
    parameter int VTOTAL    = 256,
    parameter int VBL_END   = 24,
    parameter int VS_START  = 4,
    parameter int VS_END    = 7,
    parameter int IRQ_BIT   = 5,
    parameter int FCW       = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ce,
    input  logic [VW-1:0]  cmp_line,
    input  logic           cmp_en,
    input  logic           irq_ack,
    output logic [HW-1:0]  hcount,
    output logic [VW-1:0]  vcount,
    output logic           hsync,
    output logic           vsync,
    output logic           hblank,
    output logic           vblank,
    output logic           hblank_d1,
    output logic           hblank_d2,
    output logic           line_start,
    output logic           frame_start,
    output logic           irq_periodic,
    output logic           irq_cmp,
    output logic           field,
    output logic [FCW-1:0] frame_cnt
);

    localparam logic [HW-1:0] c_htot_m1   = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] c_vtot_m1   = VW'(VTOTAL - 1);
    localparam logic [HW-1:0] c_hbl_start = HW'(HBL_START);
    localparam logic [HW-1:0] c_hs_start  = HW'(HS_START);
    localparam logic [HW-1:0] c_hs_end    = HW'(HS_END);
    localparam logic [HW-1:0] c_d1_start  = HW'(HBL_START + HB_DLY1);
    localparam logic [HW-1:0] c_d2_start  = HW'(HBL_START + HB_DLY2);
    localparam logic [HW-1:0] c_dly1      = HW'(HB_DLY1);
    localparam logic [HW-1:0] c_dly2      = HW'(HB_DLY2);
    localparam logic [VW-1:0] c_vbl_end   = VW'(VBL_END);
    localparam logic [VW-1:0] c_vs_start  = VW'(VS_START);
    localparam logic [VW-1:0] c_vs_end    = VW'(VS_END);

    generate
        if (!(HS_START < HS_END && HS_END <= HTOTAL && HB_DLY1 <= HB_DLY2 &&
              HBL_START + HB_DLY2 <= HTOTAL && VS_END <= VTOTAL &&
              VBL_END <= VTOTAL)) begin : g_bad_params
            $error("video_timing_gen: illegal timing parameters");
        end
    endgenerate

    logic [HW-1:0]  hcount_q, hcount_d;
    logic [VW-1:0]  vcount_q, vcount_d;
    logic           hsync_q, hsync_d;
    logic           hbd1_q, hbd1_d;
    logic           hbd2_q, hbd2_d;
    logic           irq_cmp_q, irq_cmp_d;
    logic           field_q, field_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           w_hwrap;
    logic           w_frame_wrap;
    logic           w_cmp_set;

    assign w_hwrap      = ce && (hcount_q == c_htot_m1);
    assign w_frame_wrap = w_hwrap && (vcount_q == c_vtot_m1);

    // Sync and taps compare the next count so they switch on the same ce edge as hcount.
    always_comb begin
        hcount_d    = hcount_q;
        vcount_d    = vcount_q;
        hsync_d     = hsync_q;
        hbd1_d      = hbd1_q;
        hbd2_d      = hbd2_q;
        field_d     = field_q;
        frame_cnt_d = frame_cnt_q;
        if (ce) begin
            if (w_hwrap) begin
                hcount_d = '0;
                vcount_d = (vcount_q == c_vtot_m1) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
            hsync_d = (hcount_d >= c_hs_start) && (hcount_d < c_hs_end);
            hbd1_d  = (hcount_d >= c_d1_start) || (hcount_d < c_dly1);
            hbd2_d  = (hcount_d >= c_d2_start) || (hcount_d < c_dly2);
        end
        if (w_frame_wrap) begin
            field_d     = ~field_q;
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    // A set on the same clk as an ack wins; cmp_en only gates new sets.
    assign w_cmp_set = w_hwrap && cmp_en && (vcount_d == cmp_line);

    always_comb begin
        irq_cmp_d = irq_cmp_q;
        if (w_cmp_set) begin
            irq_cmp_d = 1'b1;
        end else if (irq_ack) begin
            irq_cmp_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q    <= '0;
            vcount_q    <= '0;
            hsync_q     <= 1'b0;
            hbd1_q      <= 1'b0;
            hbd2_q      <= 1'b0;
            irq_cmp_q   <= 1'b0;
            field_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            hsync_q     <= hsync_d;
            hbd1_q      <= hbd1_d;
            hbd2_q      <= hbd2_d;
            irq_cmp_q   <= irq_cmp_d;
            field_q     <= field_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign hcount       = hcount_q;
    assign vcount       = vcount_q;
    assign hsync        = hsync_q;
    assign hblank_d1    = hbd1_q;
    assign hblank_d2    = hbd2_q;
    assign irq_cmp      = irq_cmp_q;
    assign field        = field_q;
    assign frame_cnt    = frame_cnt_q;
    assign hblank       = (hcount_q >= c_hbl_start);
    assign vblank       = (vcount_q < c_vbl_end);
    assign vsync        = (vcount_q >= c_vs_start) && (vcount_q < c_vs_end);
    assign irq_periodic = ~vcount_q[IRQ_BIT];
    // Pulses are held low while reset is asserted even though hcount reads 0.
    assign line_start   = reset_n && ce && (hcount_q == '0);
    assign frame_start  = line_start && (vcount_q == '0);

endmodule
`default_nettype wire
